// File: rtl/axiuart_frame_pkg.sv
// rtl/axiuart_frame_pkg.sv - shared frame constants, status codes, builder states and CRC polynomial
package axiuart_frame_pkg;

   localparam logic [7:0] SOF_D2H_DEFAULT  = 8'h55;

   localparam logic [7:0] STATUS_OK        = 8'h00;
   localparam logic [7:0] STATUS_CRC_ERR   = 8'h01;
   localparam logic [7:0] STATUS_CMD_INV   = 8'h02;
   localparam logic [7:0] STATUS_LEN_RANGE = 8'h03;
   localparam logic [7:0] STATUS_TIMEOUT   = 8'h04;

   localparam logic [7:0] CRC8_POLY        = 8'h07;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SOF,
      ST_STATUS,
      ST_CMD,
      ST_ADDR0,
      ST_ADDR1,
      ST_ADDR2,
      ST_ADDR3,
      ST_DATA,
      ST_CRC,
      ST_DONE
   } builder_state_e;

endpackage

// File: rtl/frame_builder_if.sv
// rtl/frame_builder_if.sv - response request and TX FIFO signals of the frame builder
interface frame_builder_if #(
   parameter int MAX_DATA_BYTES = 16
);
   localparam int LEN_W  = $clog2(MAX_DATA_BYTES + 1);
   localparam int DATA_W = 8 * MAX_DATA_BYTES;

   logic              build_req;
   logic              build_ack;
   logic [7:0]        resp_status;
   logic [7:0]        resp_cmd;
   logic [31:0]       resp_addr;
   logic [DATA_W-1:0] resp_data;
   logic [LEN_W-1:0]  resp_len;
   logic              busy;
   logic              frame_done;
   logic [7:0]        tx_fifo_data;
   logic              tx_fifo_wr_en;
   logic              tx_fifo_full;

   modport master (
      output build_req, resp_status, resp_cmd, resp_addr, resp_data, resp_len, tx_fifo_full,
      input  build_ack, busy, frame_done, tx_fifo_data, tx_fifo_wr_en
   );

   modport slave (
      input  build_req, resp_status, resp_cmd, resp_addr, resp_data, resp_len, tx_fifo_full,
      output build_ack, busy, frame_done, tx_fifo_data, tx_fifo_wr_en
   );

endinterface

// File: rtl/crc8_step.sv
// rtl/crc8_step.sv - one-byte CRC8 update, MSB first, no reflection
module crc8_step
   import axiuart_frame_pkg::*;
(
   input  logic [7:0] crc_in,
   input  logic [7:0] byte_in,
   output logic [7:0] crc_out
);

   always_comb begin
      crc_out = crc_in ^ byte_in;
      for (int i = 0; i < 8; i++) begin
         if (crc_out[7]) begin
            crc_out = {crc_out[6:0], 1'b0} ^ CRC8_POLY;
         end else begin
            crc_out = {crc_out[6:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/frame_builder.sv
// rtl/frame_builder.sv - serialises one device-to-host response frame into the TX FIFO with trailing CRC8
module frame_builder
   import axiuart_frame_pkg::*;
#(
   parameter int         MAX_DATA_BYTES = 16,
   parameter logic [7:0] SOF_DEV2HOST   = SOF_D2H_DEFAULT
)(
   input  logic          clk,
   input  logic          rst_n,
   frame_builder_if.slave bus
);

   localparam int LEN_W  = $clog2(MAX_DATA_BYTES + 1);
   localparam int IDX_W  = (MAX_DATA_BYTES > 1) ? $clog2(MAX_DATA_BYTES) : 1;
   localparam int DATA_W = 8 * MAX_DATA_BYTES;

   builder_state_e    state_q, state_d, state_nxt;
   logic [7:0]        status_q, status_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [31:0]       addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              body_q, body_d;
   logic [7:0]        crc_q, crc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   logic [7:0]        byte_out;
   logic [7:0]        crc_next;
   logic [7:0]        acc_status;
   logic              byte_state;
   logic              covered;
   logic              wr_en;
   logic              ack;
   logic              last_data;
   logic              len_over;

   crc8_step u_crc8_step (
      .crc_in  (crc_q),
      .byte_in (byte_out),
      .crc_out (crc_next)
   );

   assign len_over  = bus.resp_len > LEN_W'(MAX_DATA_BYTES);
   assign last_data = (LEN_W'(idx_q) == len_q - LEN_W'(1));

   // An oversize read that would otherwise succeed is downgraded before latching
   assign acc_status = (bus.resp_cmd[7] && (bus.resp_status == STATUS_OK) && len_over)
                       ? STATUS_LEN_RANGE : bus.resp_status;

   always_comb begin
      byte_out   = 8'h00;
      byte_state = 1'b0;
      covered    = 1'b0;
      state_nxt  = state_q;
      case (state_q)
         ST_SOF: begin
            byte_out   = SOF_DEV2HOST;
            byte_state = 1'b1;
            state_nxt  = ST_STATUS;
         end
         ST_STATUS: begin
            byte_out   = status_q;
            byte_state = 1'b1;
            covered    = 1'b1;
            state_nxt  = ST_CMD;
         end
         ST_CMD: begin
            byte_out   = cmd_q;
            byte_state = 1'b1;
            covered    = 1'b1;
            state_nxt  = body_q ? ST_ADDR0 : ST_CRC;
         end
         ST_ADDR0: begin
            byte_out   = addr_q[7:0];
            byte_state = 1'b1;
            covered    = 1'b1;
            state_nxt  = ST_ADDR1;
         end
         ST_ADDR1: begin
            byte_out   = addr_q[15:8];
            byte_state = 1'b1;
            covered    = 1'b1;
            state_nxt  = ST_ADDR2;
         end
         ST_ADDR2: begin
            byte_out   = addr_q[23:16];
            byte_state = 1'b1;
            covered    = 1'b1;
            state_nxt  = ST_ADDR3;
         end
         ST_ADDR3: begin
            byte_out   = addr_q[31:24];
            byte_state = 1'b1;
            covered    = 1'b1;
            state_nxt  = (len_q == '0) ? ST_CRC : ST_DATA;
         end
         ST_DATA: begin
            byte_out   = data_q[{idx_q, 3'b000} +: 8];
            byte_state = 1'b1;
            covered    = 1'b1;
            state_nxt  = last_data ? ST_CRC : ST_DATA;
         end
         ST_CRC: begin
            byte_out   = crc_q;
            byte_state = 1'b1;
            state_nxt  = ST_DONE;
         end
         default: begin
            byte_out   = 8'h00;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      data_d   = data_q;
      len_d    = len_q;
      body_d   = body_q;
      crc_d    = crc_q;
      idx_d    = idx_q;
      ack      = 1'b0;
      wr_en    = byte_state && !bus.tx_fifo_full;

      case (state_q)
         ST_IDLE: begin
            if (bus.build_req) begin
               ack      = 1'b1;
               status_d = acc_status;
               cmd_d    = bus.resp_cmd;
               addr_d   = bus.resp_addr;
               data_d   = bus.resp_data;
               len_d    = bus.resp_len;
               body_d   = bus.resp_cmd[7] && (acc_status == STATUS_OK);
               crc_d    = 8'h00;
               idx_d    = '0;
               state_d  = ST_SOF;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: begin
            // A stalled byte holds state, index and CRC until the FIFO drains
            if (wr_en) begin
               state_d = state_nxt;
               if (covered) begin
                  crc_d = crc_next;
               end
               if (state_q == ST_DATA) begin
                  idx_d = last_data ? '0 : idx_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         status_q <= '0;
         cmd_q    <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         len_q    <= '0;
         body_q   <= 1'b0;
         crc_q    <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         len_q    <= len_d;
         body_q   <= body_d;
         crc_q    <= crc_d;
         idx_q    <= idx_d;
      end
   end

   assign bus.build_ack     = ack;
   assign bus.busy          = (state_q != ST_IDLE);
   assign bus.frame_done    = (state_q == ST_DONE);
   assign bus.tx_fifo_data  = wr_en ? byte_out : 8'h00;
   assign bus.tx_fifo_wr_en = wr_en;

endmodule

// File: tb/tb_frame_builder.sv
// tb/tb_frame_builder.sv - directed self-checking bench for frame_builder
module tb_frame_builder;
   import axiuart_frame_pkg::*;

   localparam int MAXB = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   frame_builder_if #(.MAX_DATA_BYTES(MAXB)) bif();

   frame_builder #(.MAX_DATA_BYTES(MAXB), .SOF_DEV2HOST(8'h55)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic [7:0] cap_q[$];
   int ack_q[$];
   int done_q[$];
   int first_wr_cyc, last_wr_cyc;
   int viol       = 0;
   int stall_seen = 0;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (bif.tx_fifo_wr_en) begin
            if (cap_q.size() == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            cap_q.push_back(bif.tx_fifo_data);
         end
         if (bif.tx_fifo_wr_en && bif.tx_fifo_full) viol = viol + 1;
         if (bif.busy && bif.tx_fifo_full && !bif.tx_fifo_wr_en) stall_seen = stall_seen + 1;
         if (bif.build_ack) ack_q.push_back(cyc);
         if (bif.frame_done) done_q.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] crc8_model(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      logic fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[7] ^ b[i];
         r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return r;
   endfunction

   task automatic check_stream(input string tag, input logic [7:0] exp[$]);
      int n;
      check_eq({tag, "_len"}, cap_q.size(), exp.size());
      n = (cap_q.size() < exp.size()) ? cap_q.size() : exp.size();
      for (int i = 0; i < n; i++) check_eq($sformatf("%s[%0d]", tag, i), cap_q[i], exp[i]);
   endtask

   task automatic start_req(input logic [7:0] st, input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [127:0] data, input logic [4:0] len);
      @(posedge clk); #1;
      bif.resp_status = st;
      bif.resp_cmd    = cmd;
      bif.resp_addr   = addr;
      bif.resp_data   = data;
      bif.resp_len    = len;
      bif.build_req   = 1'b1;
   endtask

   task automatic wait_ack();
      int k;
      k = 0;
      while (!bif.build_ack && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!bif.build_ack) check_eq("ack_timeout", 0, 1);
      @(posedge clk); #1;
      bif.build_req = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!bif.frame_done && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!bif.frame_done) check_eq("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic run_frame(input logic [7:0] st, input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [127:0] data, input logic [4:0] len, output int dur);
      cap_q.delete();
      ack_q.delete();
      done_q.delete();
      start_req(st, cmd, addr, data, len);
      wait_ack();
      wait_done();
      if (ack_q.size() > 0 && done_q.size() > 0) dur = done_q[0] - ack_q[0];
      else dur = -1;
   endtask

   task automatic stall_data2();
      int k;
      k = 0;
      while (cap_q.size() != 9 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      bif.tx_fifo_full = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bif.tx_fifo_full = 1'b0;
   endtask

   logic [7:0] exp1[$], exp2[$], exp3[$], exp5[$], exp7[$];
   logic [7:0] c;
   int dur1, dur3, dur4, dur5, k6;
   localparam logic [127:0] DATA3 = 128'hEFBEADDE;

   initial begin
      bif.build_req    = 1'b0;
      bif.resp_status  = '0;
      bif.resp_cmd     = '0;
      bif.resp_addr    = '0;
      bif.resp_data    = '0;
      bif.resp_len     = '0;
      bif.tx_fifo_full = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ack", bif.build_ack, 0);
      check_eq("rst_busy", bif.busy, 0);
      check_eq("rst_done", bif.frame_done, 0);
      check_eq("rst_wr_en", bif.tx_fifo_wr_en, 0);
      check_eq("rst_data", bif.tx_fifo_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: write ack
      exp1 = '{8'h55, 8'h00, 8'h20, 8'hE0};
      run_frame(8'h00, 8'h20, 32'h0, 128'h0, 5'd0, dur1);
      check_stream("t1", exp1);
      check_eq("t1_sof_after_ack", first_wr_cyc, ack_q[0] + 1);
      check_eq("t1_done_after_crc", done_q[0], last_wr_cyc + 1);
      check_eq("t1_dur", dur1, 5);
      check_eq("t1_idle", bif.busy, 0);

      // 2: error reply suppresses addr and data
      exp2 = '{8'h55, 8'h01, 8'hA0, 8'h7C};
      run_frame(8'h01, 8'hA0, 32'h12345678, DATA3, 5'd4, dur1);
      check_stream("t2", exp2);

      // 3: read OK with payload
      exp3 = '{8'h55, 8'h00, 8'hA0, 8'h04, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      c = 8'h00;
      for (int i = 1; i < exp3.size(); i++) c = crc8_model(c, exp3[i]);
      exp3.push_back(c);
      run_frame(8'h00, 8'hA0, 32'h10000004, DATA3, 5'd4, dur3);
      check_stream("t3", exp3);
      check_eq("t3_dur", dur3, 13);

      // 4: backpressure during data byte 2
      stall_seen = 0;
      fork
         run_frame(8'h00, 8'hA0, 32'h10000004, DATA3, 5'd4, dur4);
         stall_data2();
      join
      check_stream("t4", exp3);
      check_eq("t4_dur", dur4, dur3 + 3);
      check_eq("t4_stall_cycles", stall_seen, 3);
      check_eq("t4_no_wr_while_full", viol, 0);

      // 5: length guard
      exp5 = '{8'h55, 8'h03, 8'hA0};
      exp5.push_back(crc8_model(crc8_model(8'h00, 8'h03), 8'hA0));
      run_frame(8'h00, 8'hA0, 32'h10000004, DATA3, 5'd17, dur5);
      check_stream("t5", exp5);
      check_eq("t5_dur", dur5, 5);

      // 6: reset during ADDR_BYTE1
      cap_q.delete();
      start_req(8'h00, 8'hA0, 32'h10000004, DATA3, 5'd4);
      wait_ack();
      k6 = 0;
      while (cap_q.size() != 4 && k6 < 50) begin
         @(posedge clk); #1;
         k6++;
      end
      check_eq("t6_partial_len", cap_q.size(), 4);
      check_eq("t6_wr_before_rst", bif.tx_fifo_wr_en, 1);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_wr_en", bif.tx_fifo_wr_en, 0);
      check_eq("t6_rst_busy", bif.busy, 0);
      check_eq("t6_rst_data", bif.tx_fifo_data, 0);
      check_eq("t6_rst_done", bif.frame_done, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(8'h00, 8'hA0, 32'h10000004, DATA3, 5'd4, dur3);
      check_stream("t6_after", exp3);

      // 7: build_req held high gives back-to-back frames, ignored while busy
      cap_q.delete();
      ack_q.delete();
      done_q.delete();
      exp7 = '{8'h55, 8'h00, 8'h20, 8'hE0, 8'h55, 8'h00, 8'h20, 8'hE0};
      start_req(8'h00, 8'h20, 32'h0, 128'h0, 5'd0);
      k6 = 0;
      while (done_q.size() < 2 && k6 < 40) begin
         @(posedge clk); #1;
         k6++;
      end
      bif.build_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("t7_acks", ack_q.size(), 2);
      check_eq("t7_dones", done_q.size(), 2);
      if (ack_q.size() == 2 && done_q.size() >= 1)
         check_eq("t7_b2b_accept", ack_q[1], done_q[0] + 1);
      check_stream("t7", exp7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
